// File: rtl/loopback_pkt_checker_if.sv
// rtl/loopback_pkt_checker_if.sv - frame stream bundle between loopback RX source and checker
// Purpose: groups the AXI4-Stream style frame signals.
// Signals: tdata  - frame word
//          tstrb  - byte enables, bit i covers tdata[8i+7:8i]
//          tlast  - last word of frame
//          tvalid - word valid
//          tready - sink ready
// Modports: master drives the stream, slave (the checker) drives tready.
interface loopback_pkt_checker_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tstrb, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tstrb, input tlast, input tvalid, output tready);
endinterface

// File: rtl/loopback_pkt_checker.sv
// rtl/loopback_pkt_checker.sv - receive-side checker for loopback test frames with statistics
// Purpose: sinks returned loopback frames, checks header/body/length/sequence and keeps
//          saturating counters for software.
// Ports: CLK, RESET      - clock, synchronous active-high reset
//        s_axis          - frame stream in (slave modport; tready never stalls outside reset)
//        clear_counters  - pulse: zero counters and last_err, drop sequence lock
//        good_pkt_cnt    - frames passing all checks
//        bad_pkt_cnt     - frames with any content/length error
//        seq_err_cnt     - frames whose seq differs from the expected one
//        byte_cnt        - accepted bytes (strobe popcount)
//        last_err        - error code of the most recent bad frame
// Error codes: 1 MAGIC, 2 DATA, 3 LEN, 4 RUNT, 5 OVERSIZE.
module loopback_pkt_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_WORDS  = 190,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  loopback_pkt_checker_if.slave    s_axis,
  input  logic                     clear_counters,
  output logic [CNT_WIDTH-1:0]     good_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     bad_pkt_cnt,
  output logic [CNT_WIDTH-1:0]     seq_err_cnt,
  output logic [CNT_WIDTH-1:0]     byte_cnt,
  output logic [2:0]               last_err
);
  localparam int          STRB_W = DATA_WIDTH / 8;
  localparam logic [15:0] MAGIC  = 16'hA5C3;
  localparam logic [2:0]  E_MAGIC = 3'd1, E_DATA = 3'd2, E_LEN = 3'd3,
                          E_RUNT  = 3'd4, E_OVER = 3'd5;

  typedef enum logic {HDR, BODY} state_t;
  state_t state_q, state_d;

  logic [31:0]           seq_q, expected_seq_q;
  logic [15:0]           len_q, k_q;
  logic [16:0]           frame_bytes_q;
  logic [2:0]            err_q;
  logic                  seq_locked_q;
  logic                  done_q;
  logic [2:0]            done_code_q;

  logic                  beat;
  logic [3:0]            beat_bytes;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  data_mismatch;
  logic                  strb_contig;
  logic [2:0]            beat_err;
  logic [2:0]            first_err;
  logic [17:0]           bytes_sum;
  logic [16:0]           bytes_total;
  logic [2:0]            end_code;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] v,
                                                   input logic [3:0] n);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, v} + (CNT_WIDTH+1)'(n);
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // Sink never stalls; only reset holds it off.
  assign s_axis.tready = ~RESET;
  assign beat          = s_axis.tvalid & s_axis.tready;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= HDR;
    else       state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (beat) begin
      case (state_q)
        HDR:     if (!s_axis.tlast) state_d = BODY;
        BODY:    if (s_axis.tlast)  state_d = HDR;
        default: state_d = HDR;
      endcase
    end
  end

  // Per-beat classification
  always_comb begin
    exp_word      = {seq_q, 16'h0000, k_q};
    beat_bytes    = '0;
    data_mismatch = 1'b0;
    for (int i = 0; i < STRB_W; i++) begin
      beat_bytes = beat_bytes + 4'(s_axis.tstrb[i]);
      if (s_axis.tstrb[i] && (s_axis.tdata[8*i +: 8] != exp_word[8*i +: 8]))
        data_mismatch = 1'b1;
    end
    // Contiguous-from-bit0 masks are exactly those where mask+1 clears every set bit.
    strb_contig = s_axis.tstrb[0] &&
                  ((s_axis.tstrb & (s_axis.tstrb + STRB_W'(1))) == '0);
    beat_err = '0;
    if (state_q == HDR) begin
      if (s_axis.tstrb != '1 || s_axis.tlast) beat_err = E_RUNT;
      else if (s_axis.tdata[15:0] != MAGIC)   beat_err = E_MAGIC;
    end else begin
      if (k_q >= 16'(MAX_WORDS))                                  beat_err = E_OVER;
      else if ((!s_axis.tlast && s_axis.tstrb != '1) ||
               (s_axis.tlast && !strb_contig))                     beat_err = E_LEN;
      else if (data_mismatch)                                      beat_err = E_DATA;
    end
    first_err   = (state_q == HDR || err_q == '0) ? beat_err : err_q;
    bytes_sum   = {1'b0, (state_q == HDR) ? 17'd0 : frame_bytes_q} + 18'(beat_bytes);
    bytes_total = bytes_sum[17] ? '1 : bytes_sum[16:0];
    // A runt always carries RUNT, so len_q is only consulted for frames with a body.
    end_code = (first_err != '0) ? first_err :
               (bytes_total != {1'b0, len_q}) ? E_LEN : 3'd0;
  end

  // Frame tracking and statistics
  always_ff @(posedge CLK) begin
    if (RESET) begin
      seq_q          <= '0;
      expected_seq_q <= '0;
      len_q          <= '0;
      k_q            <= '0;
      frame_bytes_q  <= '0;
      err_q          <= '0;
      seq_locked_q   <= 1'b0;
      done_q         <= 1'b0;
      done_code_q    <= '0;
      good_pkt_cnt   <= '0;
      bad_pkt_cnt    <= '0;
      seq_err_cnt    <= '0;
      byte_cnt       <= '0;
      last_err       <= '0;
    end else begin
      done_q      <= beat & s_axis.tlast;
      done_code_q <= end_code;
      if (beat) begin
        frame_bytes_q <= bytes_total;
        if (state_q == HDR) begin
          seq_q          <= s_axis.tdata[63:32];
          len_q          <= s_axis.tdata[31:16];
          k_q            <= 16'd1;
          err_q          <= beat_err;
          expected_seq_q <= s_axis.tdata[63:32] + 32'd1;
          seq_locked_q   <= 1'b1;
        end else begin
          k_q <= (&k_q) ? k_q : k_q + 16'd1;
          if (err_q == '0) err_q <= beat_err;
        end
      end
      if (clear_counters) begin
        good_pkt_cnt <= '0;
        bad_pkt_cnt  <= '0;
        seq_err_cnt  <= '0;
        byte_cnt     <= '0;
        last_err     <= '0;
        seq_locked_q <= 1'b0;
      end else begin
        if (done_q) begin
          if (done_code_q == '0) begin
            good_pkt_cnt <= sat_inc(good_pkt_cnt);
          end else begin
            bad_pkt_cnt <= sat_inc(bad_pkt_cnt);
            last_err    <= done_code_q;
          end
        end
        if (beat && state_q == HDR && seq_locked_q &&
            s_axis.tdata[63:32] != expected_seq_q)
          seq_err_cnt <= sat_inc(seq_err_cnt);
        if (beat) byte_cnt <= sat_add(byte_cnt, beat_bytes);
      end
    end
  end
endmodule

// File: tb/tb_loopback_pkt_checker.sv
// tb/tb_loopback_pkt_checker.sv - self-checking bench for loopback_pkt_checker
module tb_loopback_pkt_checker;
  logic CLK = 1'b0;
  logic RESET;
  logic clear_counters;
  always #5 CLK = ~CLK;

  loopback_pkt_checker_if bus ();
  loopback_pkt_checker_if bus_s ();
  assign bus_s.tdata  = bus.tdata;
  assign bus_s.tstrb  = bus.tstrb;
  assign bus_s.tlast  = bus.tlast;
  assign bus_s.tvalid = bus.tvalid;

  logic [31:0] good, bad, seqe, bytec;
  logic [2:0]  lerr;
  logic [2:0]  s_good, s_bad, s_seqe, s_byte, s_lerr;

  loopback_pkt_checker dut (
    .CLK(CLK), .RESET(RESET), .s_axis(bus), .clear_counters(clear_counters),
    .good_pkt_cnt(good), .bad_pkt_cnt(bad), .seq_err_cnt(seqe), .byte_cnt(bytec),
    .last_err(lerr));

  loopback_pkt_checker #(.CNT_WIDTH(3)) dut_s (
    .CLK(CLK), .RESET(RESET), .s_axis(bus_s), .clear_counters(clear_counters),
    .good_pkt_cnt(s_good), .bad_pkt_cnt(s_bad), .seq_err_cnt(s_seqe), .byte_cnt(s_byte),
    .last_err(s_lerr));

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] fw[$];
  logic [7:0]  fs[$];

  longint      m_good, m_bad, m_seqe, m_byte;
  logic [2:0]  m_last;
  logic        m_locked;
  logic [31:0] m_exp;
  logic        ready_dropped;

  always @(negedge CLK) if (!RESET && bus.tready !== 1'b1) ready_dropped = 1'b1;

  initial begin
    #900000;
    $display("FAIL timeout: run did not finish, got running, expected done");
    $fatal(1);
  end

  function automatic int pc(input logic [7:0] s);
    int c = 0;
    for (int b = 0; b < 8; b++) c += int'(s[b]);
    return c;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_good = 0; m_bad = 0; m_seqe = 0; m_byte = 0; m_last = 0; m_locked = 0; m_exp = 0;
  endtask

  task automatic model_clear();
    m_good = 0; m_bad = 0; m_seqe = 0; m_byte = 0; m_last = 0; m_locked = 0;
  endtask

  // Frame-level reference: evaluates the whole frame from the stored words.
  task automatic model_frame();
    int          n = fw.size();
    int          code = 0;
    longint      bytes = 0;
    logic [31:0] seq = fw[0][63:32];
    logic [63:0] e, w;
    logic [7:0]  s;
    int          p;
    if (fs[0] !== 8'hFF || n == 1) code = 4;
    else if (fw[0][15:0] !== 16'hA5C3) code = 1;
    for (int k = 0; k < n; k++) bytes += pc(fs[k]);
    for (int k = 1; k < n; k++) begin
      if (code == 0) begin
        s = fs[k]; w = fw[k]; p = pc(s);
        e = {seq, 16'h0000, 16'(k)};
        if (k >= 190) code = 5;
        else if ((k < n-1 && s != 8'hFF) || (k == n-1 && (p == 0 || s != 8'((1 << p) - 1))))
          code = 3;
        else
          for (int b = 0; b < 8; b++) if (s[b] && w[8*b +: 8] != e[8*b +: 8]) code = 2;
      end
    end
    if (code == 0 && bytes != longint'(fw[0][31:16])) code = 3;
    if (m_locked && seq != m_exp) m_seqe = sat(m_seqe + 1, 64'hFFFFFFFF);
    m_exp = seq + 32'd1;
    m_locked = 1'b1;
    m_byte = sat(m_byte + bytes, 64'hFFFFFFFF);
    if (code == 0) m_good = sat(m_good + 1, 64'hFFFFFFFF);
    else begin
      m_bad = sat(m_bad + 1, 64'hFFFFFFFF);
      m_last = 3'(code);
    end
  endtask

  task automatic build_frame(input logic [31:0] seq, input int nbytes, input logic [15:0] len);
    int          nw, rem;
    logic [63:0] w;
    logic [7:0]  s;
    fw.delete(); fs.delete();
    nw = (nbytes + 7) / 8;
    fw.push_back({seq, len, 16'hA5C3}); fs.push_back(8'hFF);
    for (int k = 1; k < nw; k++) begin
      rem = nbytes - 8*k;
      s = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      w = {seq, 16'h0000, 16'(k)};
      for (int b = 0; b < 8; b++) if (!s[b]) w[8*b +: 8] = 8'($urandom);
      fw.push_back(w); fs.push_back(s);
    end
  endtask

  task automatic drive_frame(input int gap_pct);
    for (int i = 0; i < fw.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge CLK);
        bus.tvalid = 1'b0; bus.tdata = {$urandom, $urandom}; bus.tlast = 1'($urandom);
      end
      @(negedge CLK);
      bus.tvalid = 1'b1; bus.tdata = fw[i]; bus.tstrb = fs[i];
      bus.tlast = (i == fw.size() - 1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      bus.tvalid = 1'b0; bus.tlast = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    @(negedge CLK); bus.tvalid = 1'b0; clear_counters = 1'b1;
    @(negedge CLK); clear_counters = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    RESET = 1'b1; clear_counters = 1'b0;
    bus.tvalid = 1'b0; bus.tlast = 1'b0; bus.tdata = '0; bus.tstrb = '0;
    repeat (3) @(negedge CLK);
    vectors++;
    if (bus.tready !== 1'b0) begin
      miscompares++; $display("FAIL reset_tready got %b expected 0", bus.tready);
    end
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    vectors++;
    if (bus.tready !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_tready got %b expected 1", bus.tready);
    end
    vectors++;
    if ({good, bad, seqe, bytec, lerr} !== 131'd0) begin
      miscompares++;
      $display("FAIL reset_counters got %h %h %h %h %h expected all 0", good, bad, seqe, bytec, lerr);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      build_frame(32'(i), 64, 16'd64); drive_frame(0); model_frame();
    end
    idle(2);
    vectors++;
    if (good !== 32'd3 || bad !== 32'd0 || seqe !== 32'd0 || bytec !== 32'd192) begin
      miscompares++;
      $display("FAIL back_to_back got good=%0d bad=%0d seq=%0d bytes=%0d expected 3 0 0 192",
               good, bad, seqe, bytec);
    end
  endtask

  task automatic test_sequence();
    pulse_clear();
    build_frame(32'd5, 64, 16'd64); drive_frame(10); model_frame();
    build_frame(32'd7, 64, 16'd64); drive_frame(10); model_frame();
    idle(2);
    vectors++;
    if (seqe !== 32'd1 || good !== 32'd2) begin
      miscompares++; $display("FAIL seq_gap got seq=%0d good=%0d expected 1 2", seqe, good);
    end
    build_frame(32'd8, 64, 16'd64); drive_frame(10); model_frame();
    idle(2);
    vectors++;
    if (seqe !== 32'd1 || good !== 32'd3) begin
      miscompares++; $display("FAIL seq_resume got seq=%0d good=%0d expected 1 3", seqe, good);
    end
  endtask

  task automatic test_mask();
    logic [63:0] w;
    pulse_clear();
    build_frame(32'd20, 60, 16'd60);
    w = fw[3]; w[23:16] ^= 8'h5A; fw[3] = w;
    drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (bad !== 32'd1 || lerr !== 3'd2 || good !== 32'd0) begin
      miscompares++; $display("FAIL mask_data got bad=%0d err=%0d good=%0d expected 1 2 0", bad, lerr, good);
    end
    pulse_clear();
    build_frame(32'd21, 60, 16'd60);
    w = fw[7]; w[47:40] ^= 8'hFF; fw[7] = w;
    drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (good !== 32'd1 || bad !== 32'd0 || fs[7] !== 8'h0F) begin
      miscompares++; $display("FAIL mask_ignored got good=%0d bad=%0d expected 1 0", good, bad);
    end
  endtask

  task automatic test_runt_magic();
    pulse_clear();
    build_frame(32'd30, 64, 16'd64);
    while (fw.size() > 1) begin void'(fw.pop_back()); void'(fs.pop_back()); end
    drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (bad !== 32'd1 || lerr !== 3'd4) begin
      miscompares++; $display("FAIL runt got bad=%0d err=%0d expected 1 4", bad, lerr);
    end
    build_frame(32'd31, 64, 16'd64);
    fw[0] = {fw[0][63:16], 16'h0000};
    drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (bad !== 32'd2 || lerr !== 3'd1) begin
      miscompares++; $display("FAIL magic got bad=%0d err=%0d expected 2 1", bad, lerr);
    end
  endtask

  task automatic test_oversize_len();
    pulse_clear();
    ready_dropped = 1'b0;
    build_frame(32'd40, 1600, 16'd1600); drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (bad !== 32'd1 || lerr !== 3'd5 || ready_dropped !== 1'b0) begin
      miscompares++;
      $display("FAIL oversize got bad=%0d err=%0d ready_dropped=%b expected 1 5 0", bad, lerr, ready_dropped);
    end
    build_frame(32'd41, 72, 16'd64); drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (bad !== 32'd2 || lerr !== 3'd3) begin
      miscompares++; $display("FAIL len_mismatch got bad=%0d err=%0d expected 2 3", bad, lerr);
    end
  endtask

  task automatic test_clear();
    build_frame(32'd50, 64, 16'd64); drive_frame(0); model_frame();
    @(negedge CLK); bus.tvalid = 1'b0; bus.tlast = 1'b0; clear_counters = 1'b1;
    @(negedge CLK); clear_counters = 1'b0;
    model_clear();
    idle(1);
    vectors++;
    if ({good, bad, seqe, bytec, lerr} !== 131'd0) begin
      miscompares++;
      $display("FAIL clear_wins got %h %h %h %h %h expected all 0", good, bad, seqe, bytec, lerr);
    end
  endtask

  task automatic test_reset_midframe();
    build_frame(32'd60, 128, 16'd128);
    while (fw.size() > 3) begin void'(fw.pop_back()); void'(fs.pop_back()); end
    drive_frame(0);
    @(negedge CLK); bus.tvalid = 1'b0; RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    model_reset();
    build_frame(32'd99, 64, 16'd64); drive_frame(0); model_frame(); idle(2);
    vectors++;
    if (good !== 32'd1 || seqe !== 32'd0 || bad !== 32'd0 || bytec !== 32'd64) begin
      miscompares++;
      $display("FAIL reset_midframe got good=%0d seq=%0d bad=%0d bytes=%0d expected 1 0 0 64",
               good, seqe, bad, bytec);
    end
  endtask

  task automatic test_random();
    int          ty, nb, k, b;
    logic [31:0] seq;
    logic [63:0] w;
    for (int f = 0; f < 40; f++) begin
      ty = $urandom_range(0, 5);
      nb = ($urandom_range(0, 9) == 0) ? $urandom_range(1500, 1700) : $urandom_range(8, 200);
      seq = ($urandom_range(0, 3) != 0) ? m_exp : $urandom;
      build_frame(seq, nb, 16'(nb));
      case (ty)
        1: fw[0] = fw[0] ^ 64'(1 << $urandom_range(0, 15));
        2: if (fw.size() > 1) begin
             k = $urandom_range(1, fw.size() - 1); b = $urandom_range(0, 7);
             w = fw[k]; w[8*b +: 8] ^= 8'h81; fw[k] = w;
           end
        3: fw[0] = {fw[0][63:32], fw[0][31:16] + 16'($urandom_range(1, 8)), fw[0][15:0]};
        4: if (fw.size() > 1) fs[$urandom_range(1, fw.size() - 1)] = 8'($urandom);
        5: while (fw.size() > 1) begin void'(fw.pop_back()); void'(fs.pop_back()); end
        default: ;
      endcase
      drive_frame(20); model_frame(); idle(2);
      vectors++;
      if ({good, bad, seqe, bytec, lerr} !==
          {32'(m_good), 32'(m_bad), 32'(m_seqe), 32'(m_byte), m_last}) begin
        miscompares++;
        $display("FAIL random_frame%0d got %0d %0d %0d %0d %0d expected %0d %0d %0d %0d %0d",
                 f, good, bad, seqe, bytec, lerr, m_good, m_bad, m_seqe, m_byte, m_last);
      end
    end
  endtask

  task automatic test_saturate();
    pulse_clear();
    for (int i = 0; i < 9; i++) begin
      build_frame(m_exp, 64, 16'd64); drive_frame(0); model_frame();
    end
    idle(2);
    vectors++;
    if (s_good !== 3'd7 || s_byte !== 3'd7 || good !== 32'd9) begin
      miscompares++;
      $display("FAIL saturate got small_good=%0d small_bytes=%0d good=%0d expected 7 7 9", s_good, s_byte, good);
    end
    vectors++;
    if ({s_good, s_bad, s_seqe, s_byte, s_lerr} !==
        {3'(sat(m_good, 7)), 3'(sat(m_bad, 7)), 3'(sat(m_seqe, 7)), 3'(sat(m_byte, 7)), m_last}) begin
      miscompares++;
      $display("FAIL saturate_model got %0d %0d %0d %0d %0d", s_good, s_bad, s_seqe, s_byte, s_lerr);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_sequence();
    test_mask();
    test_runt_magic();
    test_oversize_len();
    test_clear();
    test_reset_midframe();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
